// File: rtl/pipeline_uart_rx_fifo.sv
// pipeline_uart_rx_fifo
// Byte FIFO and CPU register front-end behind the pipeline UART receiver.
// Each rising edge of rx_status pushes rx_data. The CPU sees three registers,
// selected by addr[3:2]: RXD (0, read pops), STAT (1) and CTRL (2).
// Optional feature macro: UART_RX_IRQ_EN. It enables the CTRL.ie bit and the
// level interrupt. Without it, ie reads 0 and irq is tied low.
module pipeline_uart_rx_fifo #(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_status,
    input  logic [7:0]  rx_data,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int AW = CW - 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Pack the STAT word: not_empty, full, sticky overrun, occupancy count.
    function automatic logic [31:0] stat_word(input logic ne, input logic fu,
                                              input logic ov, input logic [CW-1:0] cnt);
        logic [31:0] w;
        w = 32'd0;
        w[0] = ne;
        w[1] = fu;
        w[2] = ov;
        w[CW+7:8] = cnt;
        return w;
    endfunction

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovr;
    logic          r_rx_status_d;
    logic [31:0]   r_rdata;

    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_rd_rxd;
    logic          w_pop;
    logic          w_wr;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_clr;
    logic          w_push;
    logic          w_ovr_evt;
    logic [CW-1:0] w_count_nxt;
    logic          w_ovr_nxt;
    logic          w_ie_rd;
    logic [31:0]   w_rdata_nxt;
    logic          w_unused_bits;

    assign w_empty    = (r_count == {CW{1'b0}});
    assign w_full     = (r_count == FULL_CNT);
    assign w_push_req = rx_status & ~r_rx_status_d;
    assign w_rd_rxd   = rd & (addr[3:2] == 2'd0);
    // A read of an empty RXD returns 0 and leaves the FIFO alone.
    assign w_pop      = w_rd_rxd & ~w_empty;
    // A store is ignored when it collides with a load.
    assign w_wr       = wr & ~rd;
    assign w_ctrl_wr  = w_wr & (addr[3:2] == 2'd2);
    assign w_flush    = w_ctrl_wr & wdata[1];
    assign w_clr      = w_ctrl_wr & wdata[2];
    // A full FIFO still accepts a byte when the same cycle frees a slot.
    assign w_push     = w_push_req & ~w_flush & (~w_full | w_pop);
    assign w_ovr_evt  = w_push_req & ~w_flush & w_full & ~w_pop;
    assign w_unused_bits = ^{addr[1:0], wdata[31:3], wdata[0]};

    // Next occupancy and overrun. A flush wins over everything.
    // A fresh overrun wins over clr_ovr in the same cycle.
    always_comb begin
        w_count_nxt = r_count;
        w_ovr_nxt   = r_ovr;
        if (w_flush) begin
            w_count_nxt = {CW{1'b0}};
            w_ovr_nxt   = 1'b0;
        end else begin
            w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
            if (w_ovr_evt) begin
                w_ovr_nxt = 1'b1;
            end else if (w_clr) begin
                w_ovr_nxt = 1'b0;
            end else begin
                w_ovr_nxt = r_ovr;
            end
        end
    end

    // Load data mux. STAT shows the state before any same-cycle push.
    always_comb begin
        w_rdata_nxt = 32'd0;
        case (addr[3:2])
            2'd0: begin
                if (w_empty) begin
                    w_rdata_nxt = 32'd0;
                end else begin
                    w_rdata_nxt = {24'd0, r_mem[r_rptr]};
                end
            end
            2'd1:    w_rdata_nxt = stat_word(~w_empty, w_full, r_ovr, r_count);
            2'd2:    w_rdata_nxt = {31'd0, w_ie_rd};
            default: w_rdata_nxt = 32'd0;
        endcase
    end

    // Store the byte at the write pointer. The array is not reset, because
    // the count gates every read of it.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    // Pointers, count, overrun, strobe history and the registered load data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr        <= {AW{1'b0}};
            r_rptr        <= {AW{1'b0}};
            r_count       <= {CW{1'b0}};
            r_ovr         <= 1'b0;
            r_rx_status_d <= 1'b1;
            r_rdata       <= 32'd0;
        end else begin
            r_rx_status_d <= rx_status;
            r_count       <= w_count_nxt;
            r_ovr         <= w_ovr_nxt;
            if (w_flush) begin
                r_wptr <= {AW{1'b0}};
                r_rptr <= {AW{1'b0}};
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            if (rd) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    assign rdata = r_rdata;

`ifdef UART_RX_IRQ_EN
    logic r_ie;
    logic r_irq;
    logic w_ie_nxt;

    assign w_ie_nxt = w_ctrl_wr ? wdata[0] : r_ie;
    assign w_ie_rd  = r_ie;

    // Interrupt enable and a level interrupt taken from next-state occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_ie  <= w_ie_nxt;
            r_irq <= w_ie_nxt & (w_count_nxt != {CW{1'b0}});
        end
    end

    assign irq = r_irq;
`else
    assign w_ie_rd = 1'b0;
    assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_uart_rx_fifo.sv
// Randomized plus directed bench for pipeline_uart_rx_fifo. A queue-based
// reference model predicts rdata and irq after every clock edge.
module tb_pipeline_uart_rx_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        rx_status;
    logic [7:0]  rx_data;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_total;
    int n_bad;

    // reference model state
    logic [7:0]  m_q[$];
    logic        m_ovr;
    logic        m_ie;
    logic        m_prev;
    logic [31:0] m_rdata;
    logic        m_irq;

    pipeline_uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx_status(rx_status), .rx_data(rx_data),
        .addr(addr), .rd(rd), .wr(wr), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One clock edge of the model, computed from the register-map rules.
    task automatic model_step();
        logic       rise;
        logic       is_wr;
        logic [1:0] sel;
        int         sz;
        if (!reset) begin
            m_q.delete();
            m_ovr   = 1'b0;
            m_ie    = 1'b0;
            m_prev  = 1'b1;
            m_rdata = 32'd0;
            m_irq   = 1'b0;
        end else begin
            rise   = rx_status && !m_prev;
            m_prev = rx_status;
            is_wr  = wr && !rd;
            sel    = addr[3:2];
            sz     = m_q.size();
            if (rd) begin
                if (sel == 2'd0) begin
                    m_rdata = (sz > 0) ? {24'd0, m_q[0]} : 32'd0;
                    if (sz > 0) void'(m_q.pop_front());
                end else if (sel == 2'd1) begin
                    m_rdata = (sz << 8) | ((m_ovr ? 1 : 0) << 2)
                            | ((sz == DEPTH ? 1 : 0) << 1) | (sz > 0 ? 1 : 0);
                end else if (sel == 2'd2) begin
`ifdef UART_RX_IRQ_EN
                    m_rdata = {31'd0, m_ie};
`else
                    m_rdata = 32'd0;
`endif
                end else begin
                    m_rdata = 32'd0;
                end
            end
            if (is_wr && sel == 2'd2) m_ie = wdata[0];
            if (is_wr && sel == 2'd2 && wdata[1]) begin
                m_q.delete();
                m_ovr = 1'b0;
            end else begin
                if (is_wr && sel == 2'd2 && wdata[2]) m_ovr = 1'b0;
                if (rise) begin
                    if (m_q.size() < DEPTH) m_q.push_back(rx_data);
                    else m_ovr = 1'b1;
                end
            end
`ifdef UART_RX_IRQ_EN
            m_irq = m_ie && (m_q.size() > 0);
`else
            m_irq = 1'b0;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("rdata", rdata, m_rdata);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic rd_reg(input logic [3:0] a);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b; rx_status = 1'b1;
        tick();
        rx_status = 1'b0;
        tick();
    endtask

    initial begin
        int st_cnt;
        int rdprob;
        logic exp_irq_on;
        n_total = 0; n_bad = 0;
        reset = 1'b0; rx_status = 1'b0; rx_data = 8'd0; addr = 4'd0;
        rd = 1'b0; wr = 1'b0; wdata = 32'd0;
        m_prev = 1'b1; m_ovr = 1'b0; m_ie = 1'b0; m_rdata = 32'd0; m_irq = 1'b0;
`ifdef UART_RX_IRQ_EN
        exp_irq_on = 1'b1;
`else
        exp_irq_on = 1'b0;
`endif
        tick(); tick();
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;
        tick();

        // one strobe held five cycles -> one push
        rx_data = 8'h5A; rx_status = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rx_status = 1'b0;
        tick();
        rd_reg(4'h4); chk("stat_one", rdata, 32'h0000_0101);
        rd_reg(4'h0); chk("rxd_5a", rdata, 32'h0000_005A);
        rd_reg(4'h4); chk("stat_empty", rdata, 32'h0000_0000);

        // fill, overrun, drain
        for (int i = 1; i <= 9; i++) push(8'(i));
        rd_reg(4'h4); chk("stat_ovr", rdata, 32'h0000_0807);
        for (int i = 1; i <= 8; i++) begin
            rd_reg(4'h0); chk("drain", rdata, 32'(i));
        end
        rd_reg(4'h0); chk("rxd_empty", rdata, 32'd0);
        wr_reg(4'h8, 32'h4);
        rd_reg(4'h4); chk("stat_clr", rdata, 32'd0);

        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        rx_data = 8'h18; rx_status = 1'b1; addr = 4'h0; rd = 1'b1;
        tick();
        rx_status = 1'b0; rd = 1'b0;
        chk("full_pp", rdata, 32'h10);
        tick();
        rd_reg(4'h4); chk("stat_fullpp", rdata, 32'h0000_0803);

        // three bytes with overrun, then flush alongside a strobe
        push(8'h19);
        for (int i = 0; i < 5; i++) rd_reg(4'h0);
        rd_reg(4'h4); chk("stat_3ovr", rdata, 32'h0000_0305);
        rx_data = 8'hEE; rx_status = 1'b1;
        wr_reg(4'h8, 32'h2);
        rx_status = 1'b0;
        rd_reg(4'h4); chk("stat_flush", rdata, 32'd0);
        rd_reg(4'h0); chk("rxd_flush", rdata, 32'd0);

        // interrupt
        wr_reg(4'h8, 32'h1);
        rx_data = 8'h33; rx_status = 1'b1;
        tick();
        chk("irq_set", {31'd0, irq}, {31'd0, exp_irq_on});
        rx_status = 1'b0;
        tick();
        rd_reg(4'h0); chk("rxd_33", rdata, 32'h33);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd_reg(4'h8); chk("ctrl_rd", rdata, {31'd0, exp_irq_on});
        wr_reg(4'h8, 32'h0);

        // strobe high across reset release
        rx_status = 1'b1; rx_data = 8'h77; reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick(); tick(); tick();
        rd_reg(4'h4); chk("stat_rsthi", rdata, 32'd0);
        rx_status = 1'b0;
        tick();
        push(8'h77);
        rd_reg(4'h4); chk("stat_rerise", rdata, 32'h0000_0101);
        rd_reg(4'h0); chk("rxd_77", rdata, 32'h77);

        // randomized traffic
        st_cnt = 1;
        for (int i = 0; i < 4000; i++) begin
            rdprob = ((i / 250) % 2 == 0) ? 10 : 60;
            st_cnt--;
            if (st_cnt <= 0) begin
                rx_status = ~rx_status;
                if (rx_status) rx_data = 8'($urandom);
                st_cnt = $urandom_range(1, 4);
            end
            rd    = ($urandom_range(0, 99) < rdprob);
            wr    = ($urandom_range(0, 99) < 8);
            addr  = 4'($urandom_range(0, 15));
            wdata = $urandom & ~32'h2;
            if ($urandom_range(0, 5) == 0) wdata = wdata | 32'h2;
            reset = ($urandom_range(0, 599) != 0);
            tick();
        end
        rd = 1'b0; wr = 1'b0; reset = 1'b1; rx_status = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
